dsi_lane_distributor: RTL and testbench

Byte-striping scheduler that feeds the per-lane FIFOs of the D-PHY TX lanes controller from a 32-bit packet byte stream. Byte k of each packet goes to lane k mod N, where N is the active lane count. Every packet starts on lane 0. The LP/HS mode bit is tagged onto every FIFO entry. The block sits between the DSI packet assembler and the 4×9-bit lane FIFOs; back-pressure comes from the FIFO full flags.

---
 rtl/dsi_lane_pkg.sv | 46 ++++
 rtl/dsi_lane_distributor_if.sv | 29 ++
 rtl/dsi_byte_accumulator.sv | 49 ++++
 rtl/dsi_lane_distributor.sv | 145 ++++++++++++++
 tb/tb_dsi_lane_distributor.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsi_lane_pkg.sv
// Shared types, sizes and strobe decode for the DSI lane distributor.
package dsi_lane_pkg;

  localparam int unsigned LANES_MAX    = 4;
  localparam int unsigned FIFO_ENTRY_W = 9;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BEAT_W       = 32;
  localparam int unsigned BUF_W        = 64;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned LCNT_W       = 3;
  localparam int unsigned STAT_W       = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } dist_state_t;

  typedef struct packed {
    logic              legal;
    logic [LCNT_W-1:0] nbytes;
  } strb_info_t;

  // Only contiguous low-aligned strobes carry bytes; anything else is flagged.
  function automatic strb_info_t strb_decode(input logic [3:0] strb);
    strb_info_t info;
    info.legal  = 1'b1;
    info.nbytes = 3'd0;
    case (strb)
      4'b0000: info.nbytes = 3'd0;
      4'b0001: info.nbytes = 3'd1;
      4'b0011: info.nbytes = 3'd2;
      4'b0111: info.nbytes = 3'd3;
      4'b1111: info.nbytes = 3'd4;
      default: info.legal  = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic [LCNT_W-1:0] clamp_lanes(input logic [LCNT_W-1:0] req);
    if (req == 3'd0)      return 3'd1;
    else if (req > 3'd4)  return 3'd4;
    else                  return req;
  endfunction

endpackage

// File: rtl/dsi_lane_distributor_if.sv
// Packet-beat input and lane-FIFO write bundle of the DSI lane distributor.
interface dsi_lane_distributor_if;
  import dsi_lane_pkg::*;

  logic                                pkt_valid;
  logic [BEAT_W-1:0]                   pkt_data;
  logic [3:0]                          pkt_strb;
  logic                                pkt_last;
  logic                                pkt_lp;
  logic                                pkt_ready;
  logic [LANES_MAX*FIFO_ENTRY_W-1:0]   lanes_fifo_wdata;
  logic [LANES_MAX-1:0]                lanes_fifo_write;
  logic [LANES_MAX-1:0]                lanes_fifo_full;

  modport master (
    output pkt_valid, pkt_data, pkt_strb, pkt_last, pkt_lp,
    input  pkt_ready,
    input  lanes_fifo_wdata, lanes_fifo_write,
    output lanes_fifo_full
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_strb, pkt_last, pkt_lp,
    output pkt_ready,
    output lanes_fifo_wdata, lanes_fifo_write,
    input  lanes_fifo_full
  );

endinterface

// File: rtl/dsi_byte_accumulator.sv
// 8-byte shift buffer: shift out up to 4 head bytes, then append up to 4 bytes at the new tail.
module dsi_byte_accumulator
  import dsi_lane_pkg::*;
(
  input  logic              clk_phy,
  input  logic              rst_n,
  input  logic [LCNT_W-1:0] i_shift_cnt,
  input  logic [LCNT_W-1:0] i_append_cnt,
  input  logic [BEAT_W-1:0] i_append_data,
  output logic [BEAT_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_cnt
);

  logic [BUF_W-1:0]  r_buf;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_base;
  logic [BEAT_W-1:0] w_mask;
  logic [BUF_W-1:0]  w_shifted;
  logic [BUF_W-1:0]  w_append;

  // Bytes above cnt stay zero, so the append can simply be OR-ed in.
  always_comb begin
    w_mask = '0;
    case (i_append_cnt)
      3'd0:    w_mask = 32'h0000_0000;
      3'd1:    w_mask = 32'h0000_00FF;
      3'd2:    w_mask = 32'h0000_FFFF;
      3'd3:    w_mask = 32'h00FF_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
    w_base    = r_cnt - CNT_W'(i_shift_cnt);
    w_shifted = r_buf >> {i_shift_cnt, 3'b000};
    w_append  = {32'd0, i_append_data & w_mask} << {w_base, 3'b000};
  end

  always_ff @(posedge clk_phy or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_shifted | w_append;
      r_cnt <= w_base + CNT_W'(i_append_cnt);
    end
  end

  assign o_head = r_buf[BEAT_W-1:0];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/dsi_lane_distributor.sv
// Stripes packet bytes across the active D-PHY lane FIFOs, byte k of a packet to lane k mod n.
// Optional statistics counters are built when DSI_DISTRIB_STATS_EN is defined.
module dsi_lane_distributor
  import dsi_lane_pkg::*;
(
  input  logic                   clk_phy,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [LCNT_W-1:0]      reg_lanes_number,
  dsi_lane_distributor_if.slave  lane_if,
  output logic                   busy,
  output logic                   err_strb,
  output logic [STAT_W-1:0]      stat_packets,
  output logic [STAT_W-1:0]      stat_stall_cycles
);

  dist_state_t          r_state;
  dist_state_t          w_state_next;
  logic [LCNT_W-1:0]    r_n;
  logic                 r_lp;
  logic                 r_err;
  logic                 r_out_en;

  logic [CNT_W-1:0]     w_cnt;
  logic [BEAT_W-1:0]    w_head;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [LCNT_W-1:0]    w_r;
  logic [LANES_MAX-1:0] w_row_mask;
  logic                 w_eligible;
  logic                 w_blocked;
  logic                 w_emit;
  logic                 w_ready;
  logic                 w_accept;
  logic [LCNT_W-1:0]    w_shift;
  logic [LCNT_W-1:0]    w_add;
  strb_info_t           w_info;

  dsi_byte_accumulator u_acc (
    .clk_phy       (clk_phy),
    .rst_n         (rst_n),
    .i_shift_cnt   (w_shift),
    .i_append_cnt  (w_add),
    .i_append_data (lane_if.pkt_data),
    .o_head        (w_head),
    .o_cnt         (w_cnt)
  );

  // Row selection, back-pressure and beat acceptance.
  always_comb begin
    w_eligible = 1'b0;
    w_r        = r_n;
    w_row_mask = '0;
    case (r_state)
      ACTIVE: w_eligible = (w_cnt >= CNT_W'(r_n));
      FLUSH: begin
        w_eligible = (w_cnt != 4'd0);
        w_r        = (w_cnt < CNT_W'(r_n)) ? LCNT_W'(w_cnt) : r_n;
      end
      default: w_eligible = 1'b0;
    endcase
    case (w_r)
      3'd0:    w_row_mask = 4'b0000;
      3'd1:    w_row_mask = 4'b0001;
      3'd2:    w_row_mask = 4'b0011;
      3'd3:    w_row_mask = 4'b0111;
      default: w_row_mask = 4'b1111;
    endcase
    w_blocked  = |(lane_if.lanes_fifo_full & w_row_mask);
    w_emit     = w_eligible && !w_blocked;
    w_shift    = w_emit ? w_r : 3'd0;
    w_ready    = r_out_en && enable && (r_state != FLUSH) && (w_cnt <= 4'd4);
    w_accept   = lane_if.pkt_valid && w_ready;
    w_info     = strb_decode(lane_if.pkt_strb);
    w_add      = (w_accept && w_info.legal) ? w_info.nbytes : 3'd0;
    w_cnt_next = w_cnt - CNT_W'(w_shift) + CNT_W'(w_add);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = lane_if.pkt_last ? FLUSH : ACTIVE;
      ACTIVE:  if (w_accept && lane_if.pkt_last) w_state_next = FLUSH;
      FLUSH:   if (w_cnt_next == 4'd0) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_phy or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Lane count and mode are frozen for the packet at its first accepted beat.
  always_ff @(posedge clk_phy or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= 3'd1;
      r_lp     <= 1'b0;
      r_err    <= 1'b0;
      r_out_en <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (r_state == IDLE && w_accept) begin
        r_n  <= clamp_lanes(reg_lanes_number);
        r_lp <= lane_if.pkt_lp;
      end
      if (w_accept && !w_info.legal) r_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < LANES_MAX; i++) begin : g_lane
    assign lane_if.lanes_fifo_wdata[i*FIFO_ENTRY_W +: FIFO_ENTRY_W] = {r_lp, w_head[i*BYTE_W +: BYTE_W]};
  end

  assign lane_if.lanes_fifo_write = w_emit ? w_row_mask : 4'b0000;
  assign lane_if.pkt_ready        = w_ready;
  assign busy                     = (r_state != IDLE);
  assign err_strb                 = r_err;

`ifdef DSI_DISTRIB_STATS_EN
  logic [STAT_W-1:0] r_stat_packets;
  logic [STAT_W-1:0] r_stat_stall;
  logic              w_enter_flush;
  logic              w_stall;

  assign w_enter_flush = w_accept && lane_if.pkt_last;
  assign w_stall       = w_eligible && w_blocked;

  always_ff @(posedge clk_phy or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_packets <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_enter_flush) r_stat_packets <= r_stat_packets + 16'd1;
      if (w_stall)       r_stat_stall   <= r_stat_stall + 16'd1;
    end
  end

  assign stat_packets      = r_stat_packets;
  assign stat_stall_cycles = r_stat_stall;
`else
  assign stat_packets      = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Directed plus randomized bench for dsi_lane_distributor against a per-lane byte-queue model.
module tb_dsi_lane_distributor;

  logic        clk_phy = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  reg_lanes_number;
  logic        busy;
  logic        err_strb;
  logic [15:0] stat_packets;
  logic [15:0] stat_stall_cycles;

  dsi_lane_distributor_if bus ();

  dsi_lane_distributor dut (
    .clk_phy           (clk_phy),
    .rst_n             (rst_n),
    .enable            (enable),
    .reg_lanes_number  (reg_lanes_number),
    .lane_if           (bus),
    .busy              (busy),
    .err_strb          (err_strb),
    .stat_packets      (stat_packets),
    .stat_stall_cycles (stat_stall_cycles)
  );

  always #5 clk_phy = ~clk_phy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: expected and observed FIFO entries per lane.
  logic [8:0] exp_q [4][$];
  logic [8:0] got_q [4][$];
  logic [3:0] wmask_q [$];
  int         m_k, m_n, m_pkts;
  logic       m_lp;
  bit         m_first = 1'b1;
  bit         m_err   = 1'b0;

  bit         rnd_on  = 1'b0;
  logic       s_ready, s_busy;
  logic [3:0] s_write;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int clamp_n(input int req);
    return (req == 0) ? 1 : ((req > 4) ? 4 : req);
  endfunction

  // One clock: sample outputs on the falling edge, then step past the rising edge.
  task automatic tick();
    logic [3:0] full_now;
    @(negedge clk_phy);
    s_ready  = bus.pkt_ready;
    s_busy   = busy;
    s_write  = bus.lanes_fifo_write;
    full_now = bus.lanes_fifo_full;
    if (s_write != 4'd0) begin
      chk("row_contiguous", 64'(s_write & 4'(s_write + 4'd1)), 64'd0);
      chk("write_while_full", 64'(s_write & full_now), 64'd0);
      for (int j = 0; j < 4; j++)
        if (s_write[j]) got_q[j].push_back(bus.lanes_fifo_wdata[j*9 +: 9]);
      wmask_q.push_back(s_write);
    end
    @(posedge clk_phy);
    #1;
    if (rnd_on) begin
      bus.lanes_fifo_full = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      enable              = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic model_accept(input logic [31:0] d, input logic [3:0] s, input logic l,
                              input logic lp, input int lanes_req);
    logic [3:0] sp1;
    int         nb;
    if (m_first) begin
      m_n     = clamp_n(lanes_req);
      m_lp    = lp;
      m_k     = 0;
      m_first = 1'b0;
    end
    sp1 = s + 4'd1;
    nb  = $countones(s);
    if ((s & sp1) != 4'd0) m_err = 1'b1;
    else
      for (int b = 0; b < nb; b++) begin
        exp_q[m_k % m_n].push_back({m_lp, d[8*b +: 8]});
        m_k++;
      end
    if (l) begin
      m_first = 1'b1;
      m_pkts++;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic lp);
    bit ok = 1'b0;
    int waited = 0;
    int lanes_now = int'(reg_lanes_number);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = d;
    bus.pkt_strb  = s;
    bus.pkt_last  = l;
    bus.pkt_lp    = lp;
    while (!ok && waited < 400) begin
      tick();
      ok = s_ready;
      waited++;
    end
    bus.pkt_valid = 1'b0;
    if (!ok) chk("beat_timeout", 64'd0, 64'd1);
    else     model_accept(d, s, l, lp, lanes_now);
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    do begin
      tick();
      w++;
    end while (s_busy && w < 600);
    chk({tag, "_busy_low"}, 64'(s_busy), 64'd0);
  endtask

  task automatic check_lanes(input string tag);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s_lane%0d_count", tag, j), 64'(got_q[j].size()), 64'(exp_q[j].size()));
      for (int i = 0; i < exp_q[j].size() && i < got_q[j].size(); i++)
        chk($sformatf("%s_lane%0d_entry%0d", tag, j, i), 64'(got_q[j][i]), 64'(exp_q[j][i]));
      got_q[j].delete();
      exp_q[j].delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pkt_ready"}, 64'(bus.pkt_ready), 64'd0);
    chk({tag, "_write"},     64'(bus.lanes_fifo_write), 64'd0);
    chk({tag, "_wdata"},     64'(bus.lanes_fifo_wdata), 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd0);
    chk({tag, "_err_strb"},  64'(err_strb), 64'd0);
    chk({tag, "_stat_pkts"}, 64'(stat_packets), 64'd0);
    chk({tag, "_stat_stall"},64'(stat_stall_cycles), 64'd0);
  endtask

  task automatic check_stats(input string tag, input int stalls);
`ifdef DSI_DISTRIB_STATS_EN
    chk({tag, "_stat_pkts"},  64'(stat_packets), 64'(m_pkts & 16'hFFFF));
    chk({tag, "_stat_stall"}, 64'(stat_stall_cycles), 64'(stalls));
`else
    chk({tag, "_stat_pkts"},  64'(stat_packets), 64'd0);
    chk({tag, "_stat_stall"}, 64'(stat_stall_cycles), 64'(stalls * 0));
`endif
  endtask

  initial begin
    logic [3:0] t3_masks [3];
    logic [3:0] good_s [7];
    logic [3:0] bad_s [6];
    int         nbeats;
    t3_masks = '{4'b0111, 4'b0111, 4'b0011};
    good_s   = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    bad_s    = '{4'b0101, 4'b1010, 4'b0010, 4'b1000, 4'b0110, 4'b1011};

    rst_n = 1'b0; enable = 1'b1; reg_lanes_number = 3'd4;
    bus.pkt_valid = 1'b0; bus.pkt_data = '0; bus.pkt_strb = '0;
    bus.pkt_last = 1'b0; bus.pkt_lp = 1'b0; bus.lanes_fifo_full = '0;
    m_pkts = 0;
    #2;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk_phy);
    #1 rst_n = 1'b1;
    tick(); tick();

    // n=4 two full beats
    reg_lanes_number = 3'd4;
    send_beat(32'h03020100, 4'hF, 1'b0, 1'b0);
    send_beat(32'h07060504, 4'hF, 1'b1, 1'b0);
    wait_idle("t1");
    check_lanes("t1");

    // n=2 three-byte packet then single-byte packet, LP mode
    reg_lanes_number = 3'd2;
    send_beat(32'h00CCBBAA, 4'b0111, 1'b1, 1'b1);
    send_beat(32'h000000DD, 4'b0001, 1'b1, 1'b1);
    wait_idle("t2");
    check_lanes("t2");

    // n=3 eight bytes: rows of 3,3,2
    reg_lanes_number = 3'd3;
    wmask_q.delete();
    send_beat(32'h03020100, 4'hF, 1'b0, 1'b0);
    send_beat(32'h07060504, 4'hF, 1'b1, 1'b0);
    wait_idle("t3");
    chk("t3_row_count", 64'(wmask_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < wmask_q.size(); i++)
      chk($sformatf("t3_row%0d_mask", i), 64'(wmask_q[i]), 64'(t3_masks[i]));
    check_lanes("t3");

    // n=4 with lane 1 full for five cycles
    reg_lanes_number = 3'd4;
    send_beat(32'h03020100, 4'hF, 1'b0, 1'b0);
    bus.lanes_fifo_full = 4'b0010;
    send_beat(32'h07060504, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_stall_write_c%0d", i), 64'(s_write), 64'd0);
      chk($sformatf("t4_stall_ready_c%0d", i), 64'(s_ready), 64'd0);
    end
    bus.lanes_fifo_full = 4'b0000;
    send_beat(32'h0B0A0908, 4'hF, 1'b1, 1'b0);
    wait_idle("t4");
    check_lanes("t4");
    check_stats("t4", 5);

    // illegal strobe is flagged and drops its bytes
    send_beat(32'h03020100, 4'hF, 1'b0, 1'b0);
    send_beat(32'hDEADBEEF, 4'b0101, 1'b0, 1'b0);
    send_beat(32'h07060504, 4'hF, 1'b1, 1'b0);
    wait_idle("t5a");
    chk("t5_err_set", 64'(err_strb), 64'd1);
    reg_lanes_number = 3'd0;
    send_beat(32'h44332211, 4'b0111, 1'b1, 1'b1);
    wait_idle("t5b");
    chk("t5_err_sticky", 64'(err_strb), 64'd1);
    check_lanes("t5");
    check_stats("t5", 5);

    // reset while six bytes are held behind a full lane 0
    reg_lanes_number = 3'd4;
    bus.lanes_fifo_full = 4'b0001;
    send_beat(32'h03020100, 4'hF, 1'b0, 1'b0);
    send_beat(32'h0000BBAA, 4'b0011, 1'b0, 1'b1);
    tick();
    chk("t6_ready_cnt6", 64'(s_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_reset");
    for (int j = 0; j < 4; j++) begin
      exp_q[j].delete();
      got_q[j].delete();
    end
    m_first = 1'b1; m_err = 1'b0; m_pkts = 0;
    bus.lanes_fifo_full = 4'b0000;
    @(posedge clk_phy);
    #1 rst_n = 1'b1;
    tick(); tick();
    reg_lanes_number = 3'd3;
    send_beat(32'h13121110, 4'hF, 1'b0, 1'b1);
    send_beat(32'h00000014, 4'b0001, 1'b1, 1'b1);
    wait_idle("t6");
    check_lanes("t6");

    // randomized packets, lane counts, back-pressure and enable
    rnd_on = 1'b1;
    for (int p = 0; p < 40; p++) begin
      reg_lanes_number = 3'($urandom_range(0, 7));
      nbeats = $urandom_range(1, 5);
      for (int b = 0; b < nbeats; b++) begin
        logic [3:0] s;
        s = ($urandom_range(0, 15) == 0) ? bad_s[$urandom_range(0, 5)] : good_s[$urandom_range(0, 6)];
        send_beat($urandom, s, 1'(b == nbeats - 1), 1'($urandom_range(0, 1)));
        reg_lanes_number = 3'($urandom_range(0, 7));
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle("rnd");
    rnd_on = 1'b0;
    bus.lanes_fifo_full = 4'b0000;
    enable = 1'b1;
    check_lanes("rnd");
    chk("rnd_err_strb", 64'(err_strb), 64'(m_err));
`ifdef DSI_DISTRIB_STATS_EN
    chk("rnd_stat_pkts", 64'(stat_packets), 64'(m_pkts & 16'hFFFF));
`else
    chk("rnd_stat_pkts", 64'(stat_packets), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
